// File: rtl/bnn_layer_seq.sv
// Layer sequencer for the BNN core: bias load, per-group accumulate/binarize,
// two-word result readout. All core-facing controls are registered Moore outputs.
module bnn_layer_seq #(
  parameter int PSUM_STEPS = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pool_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  output logic [31:0]       data_out,
  output logic [16:0]       instruction,
  input  logic [31:0]       result_in,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_B0, S_B1, S_B2, S_CLR, S_ACC, S_BIN, S_ST0, S_ST1, S_DONE
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'(PSUM_STEPS - 1);

  state_t            state_q, state_d;
  logic [5:0]        group_q, group_d;
  logic [3:0]        step_q, step_d;
  logic              pool_q, pool_d;
  logic [5:0]        last_group;
  logic [16:0]       instr_d;
  logic              mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              busy_d, done_d;
  logic              capture;

  assign data_out   = mem_data;
  assign last_group = pool_q ? 6'd31 : 6'd7;
  assign capture    = (state_q == S_ST0) || (state_q == S_ST1);

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    group_d = group_q;
    step_d  = step_q;
    pool_d  = pool_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_B0;
        pool_d  = pool_en;
        group_d = '0;
        step_d  = '0;
      end
      S_B0:  state_d = S_B1;
      S_B1:  state_d = S_B2;
      S_B2:  state_d = S_CLR;
      S_CLR: begin
        state_d = S_ACC;
        step_d  = '0;
      end
      S_ACC: begin
        if (step_q == LAST_STEP) state_d = S_BIN;
        else                     step_d  = step_q + 4'd1;
      end
      S_BIN: begin
        if (group_q == last_group) begin
          state_d = S_ST0;
        end else begin
          state_d = S_CLR;
          group_d = group_q + 6'd1;
        end
      end
      S_ST0:   state_d = S_ST1;
      S_ST1:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up with it.
  always_comb begin
    instr_d    = '0;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    case (state_d)
      S_B0: mem_rd_d = 1'b1;
      S_B1: begin
        mem_rd_d    = 1'b1;
        mem_addr_d  = ADDR_W'(1);
        instr_d[11] = 1'b1;
      end
      S_B2:  instr_d[11] = 1'b1;
      S_CLR: instr_d[0]  = 1'b1;
      S_ACC: begin
        instr_d[9]   = 1'b1;
        instr_d[4:1] = {2'b00, step_d[1:0]};
      end
      S_BIN: begin
        instr_d[10] = 1'b1;
        instr_d[12] = pool_d;
        if (pool_d) {instr_d[13], instr_d[6]} = group_d[1:0];
      end
      S_ST0: instr_d[14] = 1'b1;
      S_ST1: begin
        instr_d[14] = 1'b1;
        instr_d[6]  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      group_q     <= '0;
      step_q      <= '0;
      pool_q      <= 1'b0;
      instruction <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      state_q     <= state_d;
      group_q     <= group_d;
      step_q      <= step_d;
      pool_q      <= pool_d;
      instruction <= instr_d;
      mem_rd      <= mem_rd_d;
      mem_addr    <= mem_addr_d;
      busy        <= busy_d;
      done        <= done_d;
      res_valid   <= capture;
      if (capture) res_data <= result_in;
    end
  end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Self-checking bench for bnn_layer_seq: per-cycle comparison of the core
// instruction stream against a list built from the layer-pass rules.
module tb_bnn_layer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pool_en;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic [31:0] data_out;
  logic [16:0] instruction;
  logic [31:0] result_in;
  logic        res_valid;
  logic [31:0] res_data;
  logic        busy, done;

  logic        start_1;
  logic [7:0]  mem_addr_1;
  logic        mem_rd_1;
  logic [31:0] mem_data_1;
  logic [31:0] data_out_1;
  logic [16:0] instruction_1;
  logic        res_valid_1;
  logic [31:0] res_data_1;
  logic        busy_1, done_1;

  logic [31:0] mem [0:255];
  logic [31:0] res_w0, res_w1;
  logic [16:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bnn_layer_seq #(.PSUM_STEPS(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pool_en(pool_en),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .data_out(data_out), .instruction(instruction), .result_in(result_in),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
  );

  bnn_layer_seq #(.PSUM_STEPS(1), .ADDR_W(8)) dut_1 (
    .clk(clk), .rst(rst), .start(start_1), .pool_en(1'b0),
    .mem_addr(mem_addr_1), .mem_rd(mem_rd_1), .mem_data(mem_data_1),
    .data_out(data_out_1), .instruction(instruction_1), .result_in(32'h0),
    .res_valid(res_valid_1), .res_data(res_data_1), .busy(busy_1), .done(done_1)
  );

  // Synchronous bias memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd)   mem_data   <= mem[mem_addr];
    if (mem_rd_1) mem_data_1 <= mem[mem_addr_1];
  end

  // Core model: drives the chosen result words while store is asserted.
  always_comb begin
    result_in = 32'hDEAD_BEEF;
    if (instruction[14]) result_in = instruction[6] ? res_w1 : res_w0;
  end

  // Expected instruction word for every busy cycle of one pass (B0 .. S1).
  task automatic build_exp(input bit pool, input int p);
    logic [16:0] w;
    int g_count;
    g_count = pool ? 32 : 8;
    exp_q.delete();
    exp_q.push_back(17'h0);
    w = '0; w[11] = 1'b1;
    exp_q.push_back(w);
    exp_q.push_back(w);
    for (int g = 0; g < g_count; g++) begin
      w = '0; w[0] = 1'b1;
      exp_q.push_back(w);
      for (int s = 0; s < p; s++) begin
        w = '0; w[9] = 1'b1; w[4:1] = 4'(s % 4);
        exp_q.push_back(w);
      end
      w = '0; w[10] = 1'b1;
      if (pool) begin
        w[12] = 1'b1;
        w[13] = ((g % 4) >= 2);
        w[6]  = ((g % 2) == 1);
      end
      exp_q.push_back(w);
    end
    w = '0; w[14] = 1'b1;
    exp_q.push_back(w);
    w[6] = 1'b1;
    exp_q.push_back(w);
  endtask

  // One pass on the PSUM_STEPS=4 instance; optional ignored start pulse,
  // start held high, or reset abort at busy-cycle index abort_at.
  task automatic run_pass(input bit pool, input int mid_start, input bit hold, input int abort_at);
    int len;
    int ops;
    build_exp(pool, 4);
    len = exp_q.size();
    @(negedge clk); pool_en = pool; start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0; pool_en = ~pool;
    for (int k = 0; k < len; k++) begin
      vectors++; if (instruction !== exp_q[k]) begin miscompares++; $display("FAIL instr k=%0d: got %h expected %h", k, instruction, exp_q[k]); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy k=%0d: got %b expected 1", k, busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_early k=%0d: got %b expected 0", k, done); end
      vectors++; if (mem_rd !== (k < 2)) begin miscompares++; $display("FAIL mem_rd k=%0d: got %b expected %b", k, mem_rd, (k < 2)); end
      if (k < 2) begin
        vectors++; if (mem_addr !== 8'(k)) begin miscompares++; $display("FAIL mem_addr k=%0d: got %h expected %h", k, mem_addr, 8'(k)); end
      end
      if (k == 1 || k == 2) begin
        vectors++; if (data_out !== mem[k-1]) begin miscompares++; $display("FAIL data_out k=%0d: got %h expected %h", k, data_out, mem[k-1]); end
      end
      if (k >= 1) begin
        ops = int'(instruction[0]) + int'(instruction[9]) + int'(instruction[10]) + int'(instruction[11]) + int'(instruction[14]);
        vectors++; if (ops != 1) begin miscompares++; $display("FAIL onehot k=%0d: got %0d ops expected 1", k, ops); end
      end
      vectors++; if (res_valid !== (k == len - 1)) begin miscompares++; $display("FAIL res_valid k=%0d: got %b expected %b", k, res_valid, (k == len - 1)); end
      if (k == len - 1) begin
        vectors++; if (res_data !== res_w0) begin miscompares++; $display("FAIL res_word0: got %h expected %h", res_data, res_w0); end
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        vectors++; if (instruction !== 17'h0) begin miscompares++; $display("FAIL abort_instr: got %h expected 0", instruction); end
        vectors++; if ({busy, done, mem_rd, res_valid} !== 4'b0) begin miscompares++; $display("FAIL abort_ctrl: got %b expected 0000", {busy, done, mem_rd, res_valid}); end
        vectors++; if ({mem_addr, res_data} !== 40'h0) begin miscompares++; $display("FAIL abort_data: got %h expected 0", {mem_addr, res_data}); end
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          vectors++; if ({busy, done, instruction} !== 19'h0) begin miscompares++; $display("FAIL abort_quiet i=%0d: got %h expected 0", i, {busy, done, instruction}); end
        end
        return;
      end
      if (k == mid_start) start = 1'b1;
      else if (!hold)     start = 1'b0;
      @(negedge clk);
    end
    vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL done_cycle: got busy,done=%b expected 01", {busy, done}); end
    vectors++; if (instruction !== 17'h0) begin miscompares++; $display("FAIL done_instr: got %h expected 0", instruction); end
    vectors++; if (res_valid !== 1'b1 || res_data !== res_w1) begin miscompares++; $display("FAIL res_word1: got v=%b %h expected v=1 %h", res_valid, res_data, res_w1); end
    if (!hold) begin
      @(negedge clk);
      vectors++; if ({busy, done, res_valid} !== 3'b000) begin miscompares++; $display("FAIL post_done: got %b expected 000", {busy, done, res_valid}); end
      vectors++; if (res_data !== res_w1) begin miscompares++; $display("FAIL res_hold: got %h expected %h", res_data, res_w1); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pool_en = 1'b0; start_1 = 1'b0;
    res_w0 = 32'h0; res_w1 = 32'h0;
    repeat (3) @(negedge clk);
    vectors++; if ({instruction, mem_rd, mem_addr, busy, done, res_valid} !== 30'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", {instruction, mem_rd, mem_addr, busy, done, res_valid}); end
    vectors++; if (res_data !== 32'h0) begin miscompares++; $display("FAIL reset_res: got %h expected 0", res_data); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if ({instruction, busy, done} !== 19'h0) begin miscompares++; $display("FAIL idle_after_reset: got %h expected 0", {instruction, busy, done}); end
  endtask

  task automatic test_normal();
    mem[0] = 32'h1122_3344; mem[1] = 32'h5566_7788;
    res_w0 = $urandom; res_w1 = $urandom;
    run_pass(1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_pooled();
    mem[0] = $urandom; mem[1] = $urandom;
    res_w0 = $urandom; res_w1 = $urandom;
    run_pass(1'b1, -1, 1'b0, -1);
  endtask

  task automatic test_readout();
    res_w0 = 32'hA5A5_A5A5; res_w1 = 32'h5A5A_5A5A;
    run_pass(1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    res_w0 = $urandom; res_w1 = $urandom;
    run_pass(1'b0, 3 + 3 * 6 + 1, 1'b0, -1);
  endtask

  task automatic test_start_held();
    res_w0 = $urandom; res_w1 = $urandom;
    run_pass(1'b0, -1, 1'b1, -1);
    @(negedge clk);
    vectors++; if ({busy, done, instruction} !== 19'h0) begin miscompares++; $display("FAIL held_idle_gap: got %h expected 0", {busy, done, instruction}); end
    @(negedge clk);
    vectors++; if ({busy, mem_rd} !== 2'b11) begin miscompares++; $display("FAIL held_restart: got busy,mem_rd=%b expected 11", {busy, mem_rd}); end
    start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    res_w0 = $urandom; res_w1 = $urandom;
    run_pass(1'b1, -1, 1'b0, 3 + 5 * 6 + 2);
    mem[0] = $urandom; mem[1] = $urandom;
    run_pass(1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_psum1();
    int len;
    build_exp(1'b0, 1);
    len = exp_q.size();
    @(negedge clk); start_1 = 1'b1;
    @(negedge clk); start_1 = 1'b0;
    for (int k = 0; k < len; k++) begin
      vectors++; if (instruction_1 !== exp_q[k]) begin miscompares++; $display("FAIL p1_instr k=%0d: got %h expected %h", k, instruction_1, exp_q[k]); end
      vectors++; if ({busy_1, done_1} !== 2'b10) begin miscompares++; $display("FAIL p1_busy k=%0d: got %b expected 10", k, {busy_1, done_1}); end
      @(negedge clk);
    end
    vectors++; if ({busy_1, done_1} !== 2'b01) begin miscompares++; $display("FAIL p1_done: got %b expected 01", {busy_1, done_1}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      mem[0] = $urandom; mem[1] = $urandom;
      res_w0 = $urandom; res_w1 = $urandom;
      run_pass(1'($urandom_range(1)), int'($urandom_range(60, 3)), 1'b0, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_normal();
    test_pooled();
    test_readout();
    test_start_ignored();
    test_start_held();
    test_mid_reset();
    test_psum1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
